// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt controller: FSM states, cause
// codes, default handler vectors and the fixed-priority winner selection.
package interrupt_pkg;

  localparam int VEC_W = 10;

  localparam logic [VEC_W-1:0] DEF_VEC_EXCEPT  = 10'h3F0;
  localparam logic [VEC_W-1:0] DEF_VEC_PORT    = 10'h3F4;
  localparam logic [VEC_W-1:0] DEF_VEC_SYSCALL = 10'h3F8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_EXCEPT  = 2'b01,
    CAUSE_PORT    = 2'b10,
    CAUSE_SYSCALL = 2'b11
  } cause_t;

  typedef struct packed {
    logic except;
    logic port;
    logic syscall;
  } pend_t;

  // Exception is non-maskable; port and syscall only compete when enabled.
  function automatic cause_t pick_winner(input pend_t pend, input logic int_en);
    if (pend.except)                return CAUSE_EXCEPT;
    else if (int_en && pend.port)    return CAUSE_PORT;
    else if (int_en && pend.syscall) return CAUSE_SYSCALL;
    else                             return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge
// detector; rise is a one-cycle pulse in the clk domain.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/interrupt_ctrl.sv
// Three-source interrupt controller: sticky pending bits, fixed priority,
// non-nesting IDLE/TAKE/SERVICE handshake with registered outputs.
module interrupt_ctrl
  import interrupt_pkg::*;
#(
  parameter logic [VEC_W-1:0] VEC_EXCEPT  = DEF_VEC_EXCEPT,
  parameter logic [VEC_W-1:0] VEC_PORT    = DEF_VEC_PORT,
  parameter logic [VEC_W-1:0] VEC_SYSCALL = DEF_VEC_SYSCALL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_except,
  input  logic             i_port,
  input  logic             i_syscall,
  input  logic             s_int_en,
  input  logic             s_finished,
  output logic             s_use_interr,
  output logic [VEC_W-1:0] dir_from_exception,
  output logic             s_interruption,
  output logic [1:0]       cause
);

  state_t           state;
  pend_t            pend;
  pend_t            clr;
  cause_t           cause_q;
  cause_t           winner;
  logic [VEC_W-1:0] win_vec;
  logic             take;
  logic             port_rise;

  sync_edge u_port_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i_port),
    .rise  (port_rise)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    winner  = pick_winner(pend, s_int_en);
    take    = (state == ST_IDLE) && (winner != CAUSE_NONE);
    clr     = '0;
    win_vec = VEC_EXCEPT;
    case (winner)
      CAUSE_EXCEPT: begin
        clr.except = take;
        win_vec    = VEC_EXCEPT;
      end
      CAUSE_PORT: begin
        clr.port = take;
        win_vec  = VEC_PORT;
      end
      CAUSE_SYSCALL: begin
        clr.syscall = take;
        win_vec     = VEC_SYSCALL;
      end
      default: ;
    endcase
  end

  // A request landing on the same edge as its own take re-arms the bit:
  // it is a new request, distinct from the one being served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
    end else begin
      pend.except  <= (pend.except  & ~clr.except)  | i_except;
      pend.port    <= (pend.port    & ~clr.port)    | port_rise;
      pend.syscall <= (pend.syscall & ~clr.syscall) | i_syscall;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      s_use_interr       <= 1'b0;
      s_interruption     <= 1'b0;
      cause_q            <= CAUSE_NONE;
      dir_from_exception <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            state              <= ST_TAKE;
            s_use_interr       <= 1'b1;
            s_interruption     <= 1'b1;
            cause_q            <= winner;
            dir_from_exception <= win_vec;
          end
        end
        ST_TAKE: begin
          state        <= ST_SERVICE;
          s_use_interr <= 1'b0;
        end
        ST_SERVICE: begin
          // Leaving through IDLE guarantees at least one idle cycle between handlers.
          if (s_finished) begin
            state          <= ST_IDLE;
            s_interruption <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          s_use_interr   <= 1'b0;
          s_interruption <= 1'b0;
        end
      endcase
    end
  end

  assign cause = cause_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_interrupt_ctrl;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       i_except   = 1'b0;
  logic       i_port     = 1'b0;
  logic       i_syscall  = 1'b0;
  logic       s_int_en   = 1'b0;
  logic       s_finished = 1'b0;
  logic       s_use_interr;
  logic [9:0] dir_from_exception;
  logic       s_interruption;
  logic [1:0] cause;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  interrupt_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .i_except           (i_except),
    .i_port             (i_port),
    .i_syscall          (i_syscall),
    .s_int_en           (s_int_en),
    .s_finished         (s_finished),
    .s_use_interr       (s_use_interr),
    .dir_from_exception (dir_from_exception),
    .s_interruption     (s_interruption),
    .cause              (cause)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Sources indexed 0=exception, 1=port, 2=syscall.
  // port_seen[j] is i_port as sampled j+1 edges ago; a port request counts
  // two edges after it was first sampled high.
  logic [9:0] vec_tab [3] = '{10'h3F0, 10'h3F4, 10'h3F8};
  bit         m_pend [3];
  bit         port_seen [3];
  bit         m_use, m_busy;
  logic [1:0] m_cause = 2'b00;
  logic [9:0] m_vec   = 10'h000;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i]    = 1'b0;
      port_seen[i] = 1'b0;
    end
    m_use   = 1'b0;
    m_busy  = 1'b0;
    m_cause = 2'b00;
    m_vec   = 10'h000;
  endtask

  task automatic model_step();
    int w;
    bit port_req;
    port_req     = port_seen[1] && !port_seen[2];
    port_seen[2] = port_seen[1];
    port_seen[1] = port_seen[0];
    port_seen[0] = i_port;
    w = -1;
    if (!m_busy) begin
      if (m_pend[0])                  w = 0;
      else if (s_int_en && m_pend[1]) w = 1;
      else if (s_int_en && m_pend[2]) w = 2;
    end
    if (w >= 0) begin
      m_use     = 1'b1;
      m_busy    = 1'b1;
      m_cause   = 2'(w + 1);
      m_vec     = vec_tab[w];
      m_pend[w] = 1'b0;
    end else if (m_use) begin
      m_use = 1'b0;
    end else if (m_busy && s_finished) begin
      m_busy = 1'b0;
    end
    if (i_except)  m_pend[0] = 1'b1;
    if (port_req)  m_pend[1] = 1'b1;
    if (i_syscall) m_pend[2] = 1'b1;
  endtask

  always @(negedge reset) model_reset();

  always @(posedge clk) begin
    if (!reset) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    check("model_use",   16'(s_use_interr),       16'(m_use));
    check("model_busy",  16'(s_interruption),     16'(m_busy));
    check("model_cause", 16'(cause),              16'(m_cause));
    check("model_vec",   16'(dir_from_exception), 16'(m_vec));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic finish_handler();
    s_finished = 1'b1;
    tick();
    s_finished = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tick(2);
    check("rst_use",   16'(s_use_interr),       16'h0);
    check("rst_busy",  16'(s_interruption),     16'h0);
    check("rst_cause", 16'(cause),              16'h0);
    check("rst_vec",   16'(dir_from_exception), 16'h0);
    reset = 1'b1;
    tick();

    // Single syscall: one-cycle take, then service until s_finished.
    s_int_en  = 1'b1;
    i_syscall = 1'b1;
    tick();
    i_syscall = 1'b0;
    check("sys_latency_use", 16'(s_use_interr), 16'h0);
    tick();
    check("sys_take_use",   16'(s_use_interr),       16'h1);
    check("sys_take_vec",   16'(dir_from_exception), 16'h3F8);
    check("sys_take_cause", 16'(cause),              16'h3);
    check("sys_take_busy",  16'(s_interruption),     16'h1);
    tick();
    check("sys_svc_use", 16'(s_use_interr), 16'h0);
    tick(3);
    check("sys_svc_busy", 16'(s_interruption), 16'h1);
    finish_handler();
    check("sys_done_busy",  16'(s_interruption),     16'h0);
    check("sys_done_cause", 16'(cause),              16'h3);
    check("sys_done_vec",   16'(dir_from_exception), 16'h3F8);

    // s_finished in IDLE changes nothing.
    finish_handler();
    tick();
    check("idle_fin_use",   16'(s_use_interr),       16'h0);
    check("idle_fin_busy",  16'(s_interruption),     16'h0);
    check("idle_fin_cause", 16'(cause),              16'h3);
    check("idle_fin_vec",   16'(dir_from_exception), 16'h3F8);

    // Exception and syscall together: exception first, syscall after one idle cycle.
    i_except  = 1'b1;
    i_syscall = 1'b1;
    tick();
    i_except  = 1'b0;
    i_syscall = 1'b0;
    tick();
    check("prio_exc_use",   16'(s_use_interr),       16'h1);
    check("prio_exc_vec",   16'(dir_from_exception), 16'h3F0);
    check("prio_exc_cause", 16'(cause),              16'h1);
    tick();
    finish_handler();
    check("prio_idle_busy", 16'(s_interruption), 16'h0);
    check("prio_idle_use",  16'(s_use_interr),   16'h0);
    tick();
    check("prio_sys_use",   16'(s_use_interr),       16'h1);
    check("prio_sys_vec",   16'(dir_from_exception), 16'h3F8);
    check("prio_sys_cause", 16'(cause),              16'h3);
    tick();
    finish_handler();

    // Masked port request waits for the enable.
    s_int_en = 1'b0;
    i_port   = 1'b1;
    tick(10);
    check("port_masked_busy", 16'(s_interruption), 16'h0);
    check("port_masked_use",  16'(s_use_interr),   16'h0);
    s_int_en = 1'b1;
    tick();
    check("port_take_use",   16'(s_use_interr),       16'h1);
    check("port_take_vec",   16'(dir_from_exception), 16'h3F4);
    check("port_take_cause", 16'(cause),              16'h2);
    i_port = 1'b0;
    tick();
    finish_handler();

    // Syscall during exception service must wait for s_finished.
    i_except = 1'b1;
    tick();
    i_except = 1'b0;
    tick(2);
    i_syscall = 1'b1;
    tick();
    i_syscall = 1'b0;
    tick(3);
    check("nest_use",   16'(s_use_interr),   16'h0);
    check("nest_busy",  16'(s_interruption), 16'h1);
    check("nest_cause", 16'(cause),          16'h1);
    finish_handler();
    check("nest_idle_busy", 16'(s_interruption), 16'h0);
    tick();
    check("nest_sys_use",   16'(s_use_interr), 16'h1);
    check("nest_sys_cause", 16'(cause),        16'h3);
    tick();
    finish_handler();

    // Asynchronous reset during service with a port request pending.
    i_except = 1'b1;
    tick();
    i_except = 1'b0;
    tick(2);
    i_port = 1'b1;
    tick(4);
    check("arst_pre_busy", 16'(s_interruption), 16'h1);
    #1;
    reset = 1'b0;
    #1;
    check("arst_use",   16'(s_use_interr),       16'h0);
    check("arst_busy",  16'(s_interruption),     16'h0);
    check("arst_cause", 16'(cause),              16'h0);
    check("arst_vec",   16'(dir_from_exception), 16'h0);
    i_port = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(6);
    check("arst_after_busy", 16'(s_interruption), 16'h0);
    check("arst_after_use",  16'(s_use_interr),   16'h0);

    // Randomized traffic, checked every cycle by the model comparison.
    repeat (2000) begin
      tick();
      i_except   = ($urandom_range(0, 15) == 0);
      i_syscall  = ($urandom_range(0, 7) == 0);
      s_finished = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0)  i_port   = ~i_port;
      if ($urandom_range(0, 19) == 0) s_int_en = ~s_int_en;
      if ($urandom_range(0, 199) == 0) begin
        #1;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
      end
    end
    i_except   = 1'b0;
    i_syscall  = 1'b0;
    s_finished = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
